preamble_map_tx: RTL and testbench

- TX-side counterpart of the receiver's ML preamble correlator taps.
- Streams the 802.11a short-training (STS) and long-training (LTS) frequency-domain symbols, one subcarrier per beat, into the TX IFFT ahead of the DATA symbols.
- Uses the same 2-bit known-coefficient coding as the RX side. Subcarrier values come from a coefficient ROM and are scaled by parameterised amplitudes.
- The downstream IFFT and cyclic-prefix stage handle GI and repetition timing.

---
 rtl/preamble_pkg.sv | 53 +++++
 rtl/preamble_coeff_rom.sv | 24 ++
 rtl/preamble_map_tx.sv | 147 ++++++++++++++
 tb/tb_preamble_map_tx.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/preamble_pkg.sv
// Shared constants for the 802.11a preamble mapper:
// coefficient codes, FSM encoding and STS/LTS code tables.
package preamble_pkg;

    localparam logic [1:0] CODE_ZERO = 2'b00;
    localparam logic [1:0] CODE_POS  = 2'b01;
    localparam logic [1:0] CODE_NEG  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STS  = 2'd1,
        LTS  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef logic [63:0][1:0] code_tab_t;

    // STS code at IFFT index (0=DC, 1..31 positive k, 32..63 negative k)
    function automatic logic [1:0] sts_code(input int idx);
        case (idx)
            4, 8, 44, 52, 56:               return CODE_NEG;
            12, 16, 20, 24, 40, 48, 60:     return CODE_POS;
            default:                        return CODE_ZERO;
        endcase
    endfunction

    // LTS real-part code at IFFT index; DC and |k|>26 unused
    function automatic logic [1:0] lts_code(input int idx);
        if (idx == 0 || (idx > 26 && idx < 38))
            return CODE_ZERO;
        case (idx)
            2, 3, 6, 8, 10, 11, 12, 13, 14, 17, 18, 20, 22,
            40, 41, 44, 46, 53, 54, 57, 59: return CODE_NEG;
            default:                        return CODE_POS;
        endcase
    endfunction

    function automatic code_tab_t build_sts();
        code_tab_t t;
        for (int i = 0; i < 64; i++) t[i] = sts_code(i);
        return t;
    endfunction

    function automatic code_tab_t build_lts();
        code_tab_t t;
        for (int i = 0; i < 64; i++) t[i] = lts_code(i);
        return t;
    endfunction

    localparam code_tab_t STS_TAB = build_sts();
    localparam code_tab_t LTS_TAB = build_lts();

endpackage

// File: rtl/preamble_coeff_rom.sv
// Combinational coefficient lookup for the preamble mapper.
// STS is +/-(1+j) so Q mirrors I; LTS is purely real.
module preamble_coeff_rom
    import preamble_pkg::*;
(
    input  logic       is_lts,
    input  logic [5:0] sc_idx,
    output logic [1:0] i_code,
    output logic [1:0] q_code
);

    // Select table and derive the Q code from the symbol type
    always_comb begin
        i_code = CODE_ZERO;
        q_code = CODE_ZERO;
        if (is_lts) begin
            i_code = LTS_TAB[sc_idx];
        end else begin
            i_code = STS_TAB[sc_idx];
            q_code = STS_TAB[sc_idx];
        end
    end

endmodule

// File: rtl/preamble_map_tx.sv
// Streams STS then LTS frequency-domain symbols, one subcarrier
// per accepted beat, into the TX IFFT.
module preamble_map_tx
    import preamble_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int STS_AMP = 12058,
    parameter int LTS_AMP = 8192,
    parameter int NUM_STS = 2,
    parameter int NUM_LTS = 2
) (
    input  logic               CLK_I,
    input  logic               RST_I,
    input  logic               START_I,
    output logic [2*WIDTH-1:0] DAT_O,
    output logic               STB_O,
    input  logic               ACK_I,
    output logic               SOS_O,
    output logic               LTS_O,
    output logic               BUSY_O,
    output logic               DONE_O
);

    localparam logic [1:0] STS_LAST = 2'(NUM_STS - 1);
    localparam logic [1:0] LTS_LAST = 2'(NUM_LTS - 1);

    localparam logic [WIDTH-1:0] STS_P = WIDTH'(STS_AMP);
    localparam logic [WIDTH-1:0] STS_N = WIDTH'(-STS_AMP);
    localparam logic [WIDTH-1:0] LTS_P = WIDTH'(LTS_AMP);
    localparam logic [WIDTH-1:0] LTS_N = WIDTH'(-LTS_AMP);

    function automatic logic [WIDTH-1:0] scale(
        input logic [1:0]       code,
        input logic [WIDTH-1:0] pos,
        input logic [WIDTH-1:0] neg
    );
        case (code)
            CODE_POS: return pos;
            CODE_NEG: return neg;
            default:  return '0;
        endcase
    endfunction

    state_t             state_q, state_d;
    logic [5:0]         sc_idx_q, sc_idx_d;
    logic [1:0]         sym_cnt_q, sym_cnt_d;
    logic [2*WIDTH-1:0] dat_q, dat_d;
    logic               stb_q, stb_d;
    logic               sos_q, sos_d;
    logic               lts_q, lts_d;
    logic               done_q, done_d;

    logic       accept;
    logic       lts_next;
    logic [1:0] last_sym;
    logic [1:0] i_code, q_code;

    assign accept   = stb_q & ACK_I;
    assign lts_next = (state_d == LTS);

    // Sequencer: advance subcarrier/symbol on each accepted beat
    always_comb begin
        state_d   = state_q;
        sc_idx_d  = sc_idx_q;
        sym_cnt_d = sym_cnt_q;
        last_sym  = (state_q == STS) ? STS_LAST : LTS_LAST;
        unique case (state_q)
            IDLE: begin
                if (START_I) begin
                    state_d   = STS;
                    sc_idx_d  = '0;
                    sym_cnt_d = '0;
                end
            end
            STS, LTS: begin
                if (accept) begin
                    sc_idx_d = sc_idx_q + 6'd1;
                    if (sc_idx_q == 6'd63) begin
                        if (sym_cnt_q == last_sym) begin
                            sym_cnt_d = '0;
                            state_d   = (state_q == STS) ? LTS : DONE;
                        end else begin
                            sym_cnt_d = sym_cnt_q + 2'd1;
                        end
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    preamble_coeff_rom u_rom (
        .is_lts (lts_next),
        .sc_idx (sc_idx_d),
        .i_code (i_code),
        .q_code (q_code)
    );

    // Output stage: precompute the beat the next state will present
    always_comb begin
        stb_d  = (state_d == STS) || (state_d == LTS);
        dat_d  = '0;
        sos_d  = stb_d && (sc_idx_d == 6'd0);
        lts_d  = lts_next;
        done_d = (state_d == DONE);
        if (stb_d) begin
            if (lts_next)
                dat_d = {scale(i_code, LTS_P, LTS_N),
                         scale(q_code, LTS_P, LTS_N)};
            else
                dat_d = {scale(i_code, STS_P, STS_N),
                         scale(q_code, STS_P, STS_N)};
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            state_q   <= IDLE;
            sc_idx_q  <= '0;
            sym_cnt_q <= '0;
            dat_q     <= '0;
            stb_q     <= 1'b0;
            sos_q     <= 1'b0;
            lts_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sc_idx_q  <= sc_idx_d;
            sym_cnt_q <= sym_cnt_d;
            dat_q     <= dat_d;
            stb_q     <= stb_d;
            sos_q     <= sos_d;
            lts_q     <= lts_d;
            done_q    <= done_d;
        end
    end

    assign DAT_O  = dat_q;
    assign STB_O  = stb_q;
    assign SOS_O  = sos_q;
    assign LTS_O  = lts_q;
    assign DONE_O = done_q;
    assign BUSY_O = (state_q != IDLE);

endmodule

// File: tb/tb_preamble_map_tx.sv
// Scoreboard bench for preamble_map_tx: a subcarrier-level model
// predicts every accepted beat; monitors pop and compare.
module tb_preamble_map_tx;

    typedef struct packed {
        logic [31:0] dat;
        logic        sos;
        logic        lts;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, ack;
    logic [31:0] dat;
    logic        stb, sos, lts, busy, done;

    logic        start2, ack2;
    logic [31:0] dat2;
    logic        stb2, sos2, lts2, busy2, done2;

    int chk_cnt = 0;
    int pass_cnt = 0;

    exp_t q1[$];
    exp_t q2[$];
    exp_t e1, e2;

    logic [31:0] acc [256];
    int acc_cnt = 0;
    int done_cnt = 0;
    int acc2_cnt = 0;
    int done2_cnt = 0;

    logic        prev_stall = 1'b0;
    logic [31:0] prev_dat;
    logic        prev_sos, prev_lts;

    int sts_k [12] = '{-24, -20, -16, -12, -8, -4, 4, 8, 12, 16, 20, 24};
    int sts_s [12] = '{1, -1, 1, -1, -1, 1, -1, -1, 1, 1, 1, 1};
    int lts_n [26] = '{1, 1, -1, -1, 1, 1, -1, 1, -1, 1, 1, 1, 1,
                       1, 1, -1, -1, 1, 1, -1, 1, -1, 1, 1, 1, 1};
    int lts_p [26] = '{1, -1, -1, 1, 1, -1, 1, -1, 1, -1, -1, -1, -1,
                       -1, 1, 1, -1, -1, 1, -1, 1, -1, 1, 1, 1, 1};

    always #5 clk = ~clk;

    preamble_map_tx dut (
        .CLK_I   (clk),
        .RST_I   (rst_n),
        .START_I (start),
        .DAT_O   (dat),
        .STB_O   (stb),
        .ACK_I   (ack),
        .SOS_O   (sos),
        .LTS_O   (lts),
        .BUSY_O  (busy),
        .DONE_O  (done)
    );

    preamble_map_tx #(.NUM_STS(1), .NUM_LTS(1)) dut2 (
        .CLK_I   (clk),
        .RST_I   (rst_n),
        .START_I (start2),
        .DAT_O   (dat2),
        .STB_O   (stb2),
        .ACK_I   (ack2),
        .SOS_O   (sos2),
        .LTS_O   (lts2),
        .BUSY_O  (busy2),
        .DONE_O  (done2)
    );

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] want);
        chk_cnt++;
        if (got === want) pass_cnt++;
        else $display("FAIL %s got=%0h want=%0h", nm, got, want);
    endtask

    // Beat n of a preamble with nsts STS symbols, from the k-domain tables
    function automatic exp_t model(input int n, input int nsts);
        exp_t e;
        int sym = n / 64;
        int idx = n % 64;
        int k = (idx < 32) ? idx : idx - 64;
        int s = 0;
        e.sos = (idx == 0);
        e.lts = (sym >= nsts);
        if (!e.lts) begin
            for (int i = 0; i < 12; i++)
                if (sts_k[i] == k) s = sts_s[i];
            e.dat = {16'(s * 12058), 16'(s * 12058)};
        end else begin
            if (k >= 1 && k <= 26) s = lts_p[k - 1];
            else if (k <= -1 && k >= -26) s = lts_n[k + 26];
            e.dat = {16'(s * 8192), 16'h0};
        end
        return e;
    endfunction

    // Monitor for the default-parameter instance
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall)
                chk("stall_hold", {stb, dat, sos, lts},
                    {1'b1, prev_dat, prev_sos, prev_lts});
            if (stb && ack) begin
                if (q1.size() == 0) begin
                    chk("extra_beat", 1, 0);
                end else begin
                    e1 = q1.pop_front();
                    chk("beat", {dat, sos, lts}, {e1.dat, e1.sos, e1.lts});
                end
                if (acc_cnt < 256) acc[acc_cnt] = dat;
                acc_cnt++;
            end
            if (done) done_cnt++;
            prev_stall = stb && !ack;
            prev_dat = dat;
            prev_sos = sos;
            prev_lts = lts;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Monitor for the NUM_STS=1, NUM_LTS=1 instance
    always @(negedge clk) begin
        if (rst_n) begin
            if (stb2 && ack2) begin
                if (q2.size() == 0) begin
                    chk("extra_beat2", 1, 0);
                end else begin
                    e2 = q2.pop_front();
                    chk("beat2", {dat2, sos2, lts2},
                        {e2.dat, e2.sos, e2.lts});
                end
                acc2_cnt++;
            end
            if (done2) done2_cnt++;
        end
    end

    task automatic spot_checks();
        chk("beat0", acc[0], 32'h0000_0000);
        chk("beat4", acc[4], 32'hD0E6_D0E6);
        chk("beat60", acc[60], 32'h2F1A_2F1A);
        chk("beat129", acc[129], 32'h2000_0000);
        chk("beat130", acc[130], 32'hE000_0000);
        chk("beat154", acc[154], 32'h2000_0000);
        chk("beat160", acc[160], 32'h0000_0000);
        chk("beat166", acc[166], 32'h2000_0000);
    endtask

    // mode 0: ack=1, 1: scripted backpressure, 2: random ack
    task automatic run_stream(input int mode, input bit spur,
                              input int rst_at);
        int cyc = 0;
        int stall = 0;
        bit spur_done = 0;
        bit tgl = 0;
        int d0 = done_cnt;
        acc_cnt = 0;
        for (int n = 0; n < 256; n++) q1.push_back(model(n, 2));
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("first_beat", {stb, sos, lts, busy}, 4'b1101);
        while (!done && cyc < 5000) begin
            if (rst_at >= 0 && acc_cnt == rst_at) begin
                rst_n = 1'b0;
                @(posedge clk); #1;
                chk("rst_mid", {stb, busy, done}, 3'b000);
                rst_n = 1'b1;
                q1.delete();
                repeat (5) @(posedge clk);
                #1;
                chk("rst_no_done", done_cnt - d0, 0);
                return;
            end
            start = spur && acc_cnt == 50 && !spur_done;
            if (start) spur_done = 1;
            case (mode)
                1: begin
                    if (acc_cnt == 10 && stall < 5) begin
                        ack = 1'b0;
                        stall++;
                    end else if (acc_cnt >= 100) begin
                        tgl = !tgl;
                        ack = tgl;
                    end else begin
                        ack = 1'b1;
                    end
                end
                2: ack = 1'($urandom_range(0, 1));
                default: ack = 1'b1;
            endcase
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        if (!done) begin
            chk("timeout", 0, 1);
            return;
        end
        chk("done_outputs", {stb, dat, busy}, {1'b0, 32'h0, 1'b1});
        chk("beat_count", acc_cnt, 256);
        chk("queue_empty", q1.size(), 0);
        start = spur;
        ack = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("idle_after_done", {stb, busy, done}, 3'b000);
        chk("done_once", done_cnt - d0, 1);
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0;
        start = 1'b1;
        ack = 1'b0;
        start2 = 1'b0;
        ack2 = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_out", {stb, dat, sos, lts, busy, done}, 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;

        run_stream(0, 1, -1);
        spot_checks();
        run_stream(1, 0, -1);
        spot_checks();
        run_stream(2, 0, -1);
        run_stream(0, 0, 100);
        run_stream(0, 0, -1);
        spot_checks();

        for (int n = 0; n < 128; n++) q2.push_back(model(n, 1));
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        cyc = 0;
        while (!done2 && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("p11_done_seen", done2, 1'b1);
        chk("p11_beat_count", acc2_cnt, 128);
        chk("p11_queue_empty", q2.size(), 0);
        @(posedge clk); #1;
        chk("p11_done_once", done2_cnt, 1);
        chk("p11_idle", {stb2, busy2}, 2'b00);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
